// File: rtl/fnd_scan_ctrl_if.sv
// Bus-side bundle of the FND scan controller.
// Master = register block, slave = fnd_scan_ctrl.
interface fnd_scan_ctrl_if;
  logic        i_enable;
  logic [15:0] i_digits;
  logic [3:0]  i_dp;
  logic        i_update;
  logic [3:0]  i_brightness;
  logic [3:0]  o_digit_sel;
  logic [7:0]  o_seg;
  logic        o_frame_done;
  logic        o_pending;

  modport master (
    output i_enable, i_digits, i_dp,
    output i_update, i_brightness,
    input  o_digit_sel, o_seg,
    input  o_frame_done, o_pending
  );

  modport slave (
    input  i_enable, i_digits, i_dp,
    input  i_update, i_brightness,
    output o_digit_sel, o_seg,
    output o_frame_done, o_pending
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scan controller: blanking gap, PWM dimming, tear-free frames.
// Optional leading-zero blanking when FND_LZB_EN is defined.
module fnd_scan_ctrl #(
  parameter int DWELL_CYCLES = 15,
  parameter int BLANK_CYCLES = 2
) (
  input  logic          i_clk_fnd,
  input  logic          i_reset,
  fnd_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON,
    OFF
  } state_e;

  localparam int MAXC =
    (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [3:0] DWELL = 4'(DWELL_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    b_q, b_d;
  logic [15:0]   stg_dig_q, stg_dig_d;
  logic [3:0]    stg_dp_q, stg_dp_d;
  logic [15:0]   shd_dig_q, shd_dig_d;
  logic [3:0]    shd_dp_q, shd_dp_d;
  logic          pend_q, pend_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  logic [3:0]    bclamp;
  logic          end_c;
  logic [3:0]    nib;
  logic          dp_bit;
  logic          lzb;

  // Last cycle of a digit slot for the given state/count/brightness.
  function automatic logic slot_end(
    state_e s, logic [CW-1:0] c, logic [3:0] b
  );
    logic r;
    r = 1'b0;
    case (s)
      ON:      r = (b == DWELL) && (c == CW'(b - 4'd1));
      OFF:     r = (c == CW'(DWELL - b - 4'd1));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Active-low hex decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign bclamp =
    (bus.i_brightness > DWELL) ? DWELL : bus.i_brightness;
  assign end_c = slot_end(state_q, cnt_q, b_q);

  // Scan sequencing, frame-boundary shadow load and staging.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    b_d       = b_q;
    stg_dig_d = stg_dig_q;
    stg_dp_d  = stg_dp_q;
    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.i_enable) begin
          state_d   = BLANK;
          idx_d     = 2'd0;
          shd_dig_d = stg_dig_q;
          shd_dp_d  = stg_dp_q;
          pend_d    = 1'b0;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          b_d     = bclamp;
          state_d = (bclamp != 4'd0) ? ON : OFF;
        end
      end
      ON: begin
        if (cnt_q == CW'(b_q - 4'd1)) begin
          cnt_d   = '0;
          state_d = OFF;
        end
      end
      default: ;
    endcase
    if (end_c) begin
      cnt_d = '0;
      if (idx_q == 2'd3 && pend_q) begin
        shd_dig_d = stg_dig_q;
        shd_dp_d  = stg_dp_q;
        pend_d    = 1'b0;
      end
      if (bus.i_enable) begin
        state_d = BLANK;
        idx_d   = idx_q + 2'd1;
      end else begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    end
    if (bus.i_update) begin
      stg_dig_d = bus.i_digits;
      stg_dp_d  = bus.i_dp;
      pend_d    = 1'b1;
    end
  end

  // Pin values for the upcoming cycle, from next-state.
  always_comb begin
    nib    = shd_dig_d[{idx_d, 2'b00} +: 4];
    dp_bit = shd_dp_d[idx_d];
    lzb    = 1'b0;
`ifdef FND_LZB_EN
    unique case (idx_d)
      2'd3: lzb = (shd_dig_d[15:12] == 4'h0);
      2'd2: lzb = (shd_dig_d[15:8] == 8'h00);
      2'd1: lzb = (shd_dig_d[15:4] == 12'h000);
      2'd0: lzb = 1'b0;
    endcase
`endif
    sel_d = 4'hF;
    seg_d = 8'hFF;
    if (state_d == ON) begin
      sel_d = ~(4'b0001 << idx_d);
      seg_d = {~dp_bit, lzb ? 7'h7F : hex7(nib)};
    end
    fd_d = slot_end(state_d, cnt_d, b_d) && (idx_d == 2'd3);
  end

  // State and registered outputs, async clear.
  always_ff @(posedge i_clk_fnd or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      b_q       <= 4'd0;
      stg_dig_q <= 16'h0;
      stg_dp_q  <= 4'h0;
      shd_dig_q <= 16'h0;
      shd_dp_q  <= 4'h0;
      pend_q    <= 1'b0;
      sel_q     <= 4'hF;
      seg_q     <= 8'hFF;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      b_q       <= b_d;
      stg_dig_q <= stg_dig_d;
      stg_dp_q  <= stg_dp_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.o_digit_sel  = sel_q;
  assign bus.o_seg        = seg_q;
  assign bus.o_frame_done = fd_q;
  assign bus.o_pending    = pend_q;

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode FND. It sequences digit selection with a fixed inter-digit blanking gap to suppress ghosting and applies per-slot PWM brightness. Display data is double-buffered so updates only take effect on frame boundaries, with no tearing. It sits between the bus-facing register block and the FND pins, and replaces the free-running 2-bit digit counter for designs that need dimming or tear-free updates.

## Interface
- DWELL_CYCLES, 15: cycles per digit slot after blanking (1..15); brightness resolution.
- BLANK_CYCLES, 2: all-off cycles at the start of each digit slot (>=1).
- i_clk_fnd  in  1  scan clock, all logic on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  run scanning; level-sensitive.
- i_digits  in  16  four hex nibbles, [3:0]=digit 0 (rightmost) .. [15:12]=digit 3.
- i_dp  in  4  decimal point per digit, 1 = lit.
- i_update  in  1  one-cycle strobe: stage i_digits/i_dp.
- i_brightness  in  4  on-cycles per slot, 0 = dark, clamped to DWELL_CYCLES.
- o_digit_sel  out  4  active-low anode enables, bit n = digit n.
- o_seg  out  8  active-low cathodes, [6:0]={g,f,e,d,c,b,a}, [7]=dp.
- o_frame_done  out  1  one-cycle pulse at the end of each frame.
- o_pending  out  1  staged data not yet shown.

## Operation
- States: IDLE, BLANK, ON, OFF. Digit index idx is 2 bits and wraps 3->0.
- Reset: state IDLE, idx 0, o_digit_sel=4'b1111, o_seg=8'hFF, o_frame_done=0, o_pending=0, staging and shadow registers cleared to 0.
- IDLE: outputs off. If i_enable=1, the next state is BLANK with idx=0 and shadow<=staging, and o_pending is cleared.
- BLANK: lasts BLANK_CYCLES cycles with all anodes off. On exit, B=min(i_brightness, DWELL_CYCLES) is sampled. If B>0 the next state is ON, otherwise OFF.
- ON: lasts B cycles. o_digit_sel[idx]=0 and o_seg=decode(shadow nibble idx, shadow dp idx). If B=DWELL_CYCLES, OFF is skipped.
- OFF: lasts DWELL_CYCLES-B cycles with all anodes off.
- Slot length is always BLANK_CYCLES+DWELL_CYCLES. At the end of a slot, idx increments.
- Frame boundary is the last cycle of the idx=3 slot:
  - o_frame_done=1 for that cycle.
  - If o_pending was set before that cycle, shadow<=staging at the closing edge and o_pending clears.
- i_update: staging<=i_digits/i_dp and o_pending<=1 on the same edge. A later update overwrites staging, so the last update wins.
- Simultaneous i_update and frame boundary: shadow takes the previously staged value, staging takes the new value, and o_pending stays 1.
- i_enable deasserted: the current slot completes. At the slot end the block enters IDLE with idx=0 and no o_frame_done unless that slot was idx 3.
- Decode is hex, active-low: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- i_brightness change mid-slot has no effect until the next BLANK exit.

## Timing
- Defaults give a 17-cycle slot and a 68-cycle frame.
- First segment activity appears BLANK_CYCLES+1 cycles after the first cycle i_enable is high in IDLE.
- All outputs are registered, one cycle after the state/counter decision.
- Asynchronous reset forces outputs off immediately, mid-slot or mid-frame, and discards pending data.

## Configuration
- FND_LZB_EN defined: leading-zero blanking.
  - Digit n (n=3..1) shows blank segments (o_seg[6:0]=7'h7F) when its shadow nibble and all higher nibbles are 0.
  - The dp is still shown if set.
  - Digit 0 is never blanked.
  - Slot timing is unchanged.
- FND_LZB_EN undefined: all four digits always decode their nibble.

## Test plan
- Reset mid-ON (idx 2, brightness 15), then release: o_digit_sel=1111 and o_seg=FF immediately, o_pending=0; after release with i_enable=1, the digit 0 ON starts 3 cycles later.
- i_digits=16'h1234, i_update, i_enable, brightness 15, defaults: each slot is 2 off cycles then 15 cycles of o_digit_sel=1110/1101/1011/0111 with segs 4,3,2,1; o_frame_done every 68 cycles.
- Brightness 5: per slot exactly 5 ON cycles after 2 BLANK and 10 OFF cycles; brightness 0 gives no anode asserted over a full frame; brightness 15 gives 15 ON and 0 OFF.
- i_update of 16'hABCD during the idx 1 slot: display keeps old data through idx 3; 16'hABCD appears from the next idx 0 slot; o_pending high from update until the boundary edge; i_update on the boundary cycle gives o_pending=1 after the edge.
- i_enable dropped 3 cycles into the idx 1 slot: the slot runs its full 17 cycles, then IDLE with outputs off and no o_frame_done.
- FND_LZB_EN with 16'h0050, dp[3]=1: digits 3 and 2 show segments 7F, with digit 3 showing seg[7]=0; digit 1 shows 5 and digit 0 shows 0. Without the macro the display shows 0,0,5,0.
